mc_div_unit: RTL and testbench



---
 rtl/mc_div_if.sv | 25 ++
 rtl/mc_div_unit.sv | 138 +++++++++++++
 tb/tb_mc_div_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mc_div_if.sv
// Handshake bundle between the EX stage and the iterative divider.
// EX drives the request side (master), the divider answers (slave).
interface mc_div_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic               annul;
    logic               signed_div;
    logic [WIDTH-1:0]   opdata1;
    logic [WIDTH-1:0]   opdata2;
    logic [2*WIDTH-1:0] result;
    logic               ready;
    logic               busy;
    logic               stall_req;

    modport master (
        output start, annul, signed_div, opdata1, opdata2,
        input  result, ready, busy, stall_req
    );

    modport slave (
        input  start, annul, signed_div, opdata1, opdata2,
        output result, ready, busy, stall_req
    );
endinterface

// File: rtl/mc_div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU in EX.
// result = {remainder (HI), quotient (LO)}; stalls the pipe until ready.
module mc_div_unit #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic      clk,
    input  logic      rst,
    mc_div_if.slave   io
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ZERO,
        S_ON,
        S_END
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic               qsign_q, qsign_d;
    logic               rsign_q, rsign_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic               req;
    logic               last;
    logic               neg1, neg2;
    logic [WIDTH-1:0]   abs1, abs2;
    logic [WIDTH:0]     upper;
    logic               ge;
    logic [WIDTH-1:0]   rem_step, quo_step;
    logic [WIDTH-1:0]   rem_fix, quo_fix;

    assign req  = io.start & ~io.annul;
    assign last = (cnt_q == CNT_W'(WIDTH - 1));

    // Register all state; reset clears everything and wins over all inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dsr_q    <= '0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dsr_q    <= dsr_d;
            qsign_q  <= qsign_d;
            rsign_q  <= rsign_d;
            result_q <= result_d;
        end
    end

    // Next-state logic; annul returns to IDLE from anywhere
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (req) state_d = (io.opdata2 == '0) ? S_ZERO : S_ON;
            S_ZERO: state_d = S_END;
            S_ON:   if (last) state_d = S_END;
            S_END:  if (!io.start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (io.annul) state_d = S_IDLE;
    end

    // Operand capture, one restoring step per ON cycle, result write-back
    always_comb begin
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dsr_d    = dsr_q;
        qsign_d  = qsign_q;
        rsign_d  = rsign_q;
        result_d = result_q;

        neg1 = io.signed_div & io.opdata1[WIDTH-1];
        neg2 = io.signed_div & io.opdata2[WIDTH-1];
        abs1 = neg1 ? -io.opdata1 : io.opdata1;
        abs2 = neg2 ? -io.opdata2 : io.opdata2;

        // upper holds the shifted partial remainder; a fitting trial
        // difference is always below the divisor, so WIDTH bits suffice
        upper    = {rem_q, quo_q[WIDTH-1]};
        ge       = (upper >= {1'b0, dsr_q});
        rem_step = ge ? (upper[WIDTH-1:0] - dsr_q) : upper[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], ge};
        rem_fix  = rsign_q ? -rem_step : rem_step;
        quo_fix  = qsign_q ? -quo_step : quo_step;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    cnt_d = '0;
                    if (io.opdata2 == '0) begin
                        // raw dividend is reported back as the remainder
                        rem_d   = io.opdata1;
                        qsign_d = 1'b0;
                        rsign_d = 1'b0;
                    end else begin
                        rem_d   = '0;
                        quo_d   = abs1;
                        dsr_d   = abs2;
                        qsign_d = neg1 ^ neg2;
                        rsign_d = neg1;
                    end
                end
            end
            S_ZERO: begin
                if (!io.annul) result_d = {rem_q, {WIDTH{1'b1}}};
            end
            S_ON: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (last && !io.annul) result_d = {rem_fix, quo_fix};
            end
            default: ;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        io.ready     = (state_q == S_END);
        io.busy      = (state_q != S_IDLE);
        io.stall_req = req & (state_q != S_END);
    end

    assign io.result = result_q;
endmodule

// File: tb/tb_mc_div_unit.sv
// Directed bench for mc_div_unit: 32-bit instance plus an 8-bit instance.
// Inputs are driven and outputs sampled on the falling edge.
module tb_mc_div_unit;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mc_div_if #(.WIDTH(32)) b32 ();
    mc_div_if #(.WIDTH(8))  b8 ();

    mc_div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .io(b32));
    mc_div_unit #(.WIDTH(8))  dut8 (.clk(clk), .rst(rst), .io(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller sits on a falling edge in IDLE; that cycle is cycle 0
    task automatic run_op(input string tag, input logic sd,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [63:0] exp);
        b32.signed_div = sd;
        b32.opdata1    = a;
        b32.opdata2    = b;
        b32.start      = 1'b1;
        #1;
        check({tag, " stall0"}, 64'(b32.stall_req), 64'd1);
        repeat (lat - 1) @(negedge clk);
        check({tag, " early"}, 64'(b32.ready), 64'd0);
        @(negedge clk);
        check({tag, " ready"}, 64'(b32.ready), 64'd1);
        check({tag, " result"}, b32.result, exp);
        check({tag, " stallN"}, 64'(b32.stall_req), 64'd0);
        b32.start = 1'b0;
        @(negedge clk);
        check({tag, " idle"}, 64'({b32.busy, b32.ready}), 64'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        b32.start = 1'b0;
        b32.annul = 1'b0;
        b32.signed_div = 1'b0;
        b32.opdata1 = '0;
        b32.opdata2 = '0;
        b8.start = 1'b0;
        b8.annul = 1'b0;
        b8.signed_div = 1'b0;
        b8.opdata1 = '0;
        b8.opdata2 = '0;
        repeat (2) @(negedge clk);
        check("rst result", b32.result, 64'd0);
        check("rst flags", 64'({b32.ready, b32.busy, b32.stall_req}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("u100/7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});
        run_op("s-7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 33,
               {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_op("s7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 33,
               {32'd1, 32'hFFFFFFFD});
        run_op("uF9/2", 1'b0, 32'hFFFFFFF9, 32'd2, 33,
               {32'd1, 32'h7FFFFFFC});
        run_op("s5/0", 1'b1, 32'd5, 32'd0, 2, {32'd5, 32'hFFFFFFFF});
        run_op("u5/0", 1'b0, 32'd5, 32'd0, 2, {32'd5, 32'hFFFFFFFF});
        run_op("smin/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33,
               {32'd0, 32'h80000000});
        run_op("smin/1", 1'b1, 32'h80000000, 32'd1, 33,
               {32'd0, 32'h80000000});

        // annul together with start in IDLE starts nothing
        b32.opdata1 = 32'd100;
        b32.opdata2 = 32'd7;
        b32.signed_div = 1'b0;
        b32.start = 1'b1;
        b32.annul = 1'b1;
        #1;
        check("annul-idle stall", 64'(b32.stall_req), 64'd0);
        @(negedge clk);
        check("annul-idle busy", 64'(b32.busy), 64'd0);
        b32.annul = 1'b0;
        b32.start = 1'b0;
        @(negedge clk);

        // annul at cycle 10 of 100/7, then 9/3 from cycle 12
        b32.start = 1'b1;
        repeat (10) @(negedge clk);
        check("annul busy10", 64'(b32.busy), 64'd1);
        b32.annul = 1'b1;
        b32.start = 1'b0;
        @(negedge clk);
        b32.annul = 1'b0;
        #1;
        check("annul c11", 64'({b32.busy, b32.stall_req, b32.ready}), 64'd0);
        check("annul keep", b32.result, {32'd0, 32'h80000000});
        @(negedge clk);
        run_op("u9/3", 1'b0, 32'd9, 32'd3, 33, {32'd0, 32'd3});

        // reset at cycle 5 aborts and clears
        b32.opdata1 = 32'd100;
        b32.opdata2 = 32'd7;
        b32.start = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid-rst result", b32.result, 64'd0);
        check("mid-rst flags", 64'({b32.ready, b32.busy}), 64'd0);
        rst = 1'b0;
        b32.start = 1'b0;
        @(negedge clk);

        // operand changes while ON are ignored; result held under start
        b32.signed_div = 1'b0;
        b32.opdata1 = 32'd100;
        b32.opdata2 = 32'd7;
        b32.start = 1'b1;
        repeat (3) @(negedge clk);
        b32.opdata1 = 32'd1000;
        b32.opdata2 = 32'd3;
        b32.signed_div = 1'b1;
        repeat (30) @(negedge clk);
        check("opchg ready", 64'(b32.ready), 64'd1);
        check("opchg result", b32.result, {32'd2, 32'd14});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold ready", 64'(b32.ready), 64'd1);
            check("hold result", b32.result, {32'd2, 32'd14});
        end
        b32.start = 1'b0;
        @(negedge clk);
        check("drop flags", 64'({b32.ready, b32.busy}), 64'd0);
        check("drop result", b32.result, {32'd2, 32'd14});

        // 8-bit build: 200/9
        b8.opdata1 = 8'd200;
        b8.opdata2 = 8'd9;
        b8.start = 1'b1;
        repeat (8) @(negedge clk);
        check("w8 early", 64'(b8.ready), 64'd0);
        @(negedge clk);
        check("w8 ready", 64'(b8.ready), 64'd1);
        check("w8 result", 64'(b8.result), 64'h0216);
        b8.start = 1'b0;
        @(negedge clk);
        check("w8 idle", 64'(b8.busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
